instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Fetch/decode/execute controller that drives the ALU opcode/operand interface and consumes its
//  result and compare flags. Holds PC, IR, flags and an 8x32 register file; fetches instructions
//  and performs LDR/STR over a req/ack memory port. One instruction in flight, no pipelining.
// PARAMETERS
//  ADDR_W    16  width of PC and mem_addr (word addresses; PC increments by 1)
//  START_PC  0   PC value loaded on reset
// PORTS
//  clk                 in   1       system clock, all state on rising edge
//  rst_n               in   1       asynchronous active-low reset
//  mem_req             out  1       memory request, held until ack sampled
//  mem_we              out  1       1 = write (STR), 0 = read (fetch/LDR)
//  mem_addr            out  ADDR_W  word address
//  mem_wdata           out  32      store data (reg[rd])
//  mem_rdata           in   32      read data, valid when mem_ack=1
//  mem_ack             in   1       completes current request (may be same cycle as req)
//  alu_opcode          out  4       IR[31:28]
//  alu_addressing_mode out  1       IR[27]; 1 = register op2, 0 = immediate op2
//  alu_immediate       out  21      IR[20:0]
//  alu_reg_a_data      out  32      reg[ra]
//  alu_reg_b_data      out  32      reg[IR[2:0]]
//  alu_result          in   32      ALU result (combinational from the outputs above)
//  alu_cmp_result      in   4       {gt, lt, ne, eq}
//  pc                  out  ADDR_W  current PC
//  halted              out  1       sticky; set by HALT or illegal opcode
//  illegal             out  1       sticky; set by undefined opcode
// BEHAVIOUR
//  Format: [31:28] op, [27] mode, [26:24] rd, [23:21] ra, [20:0] imm; rb = imm[2:0].
//  Opcodes: LDR 0, STR 1, ADD 2, SUB 3, MOV 4, CMP 5, B 6, AND 8, ORR 9, EOR A, MVN B, LSL C,
//   LSR D, HALT F. 7 and E are illegal.
//  Reset: state=FETCH, pc=START_PC, ir=0, flags=0, all regs=0, mem_req=0, mem_we=0,
//   halted=0, illegal=0. ALU outputs are decodes of IR (opcode 0 etc. after reset).
//  FSM FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ack: ir<=mem_rdata, pc<=pc+1 (wraps
//   modulo 2^ADDR_W), -> DECODE.
//  DECODE (1 cycle): register reads settle to ALU, -> EXEC.
//  EXEC (1 cycle): ALU ops (2,3,4,8-D): reg[rd]<=alu_result, -> FETCH.
//   CMP: flags<=alu_cmp_result, no reg write, -> FETCH.
//   B: cond=rd field: 0 always, 1 eq, 2 ne, 3 lt, 4 gt (from flags); 5-7 never taken.
//    taken: pc<=imm[ADDR_W-1:0]. -> FETCH.
//   LDR/STR: latch addr<=alu_result[ADDR_W-1:0], -> MEM.
//   HALT: halted<=1 -> HALT. Illegal opcode: illegal<=1, halted<=1 -> HALT.
//  MEM: mem_req=1, mem_addr=latched addr, mem_we=(op==STR), mem_wdata=reg[rd].
//   On mem_ack: LDR reg[rd]<=mem_rdata; -> FETCH.
//  HALT: absorbing; mem_req=0; left only by rst_n.
//  Zero-wait memory: ALU/CMP/B = 3 cycles, LDR/STR = 4 cycles.
//  mem_req never drops while waiting for ack; addr/we/wdata stable until ack.
//  All 8 registers are general purpose (r0 not hardwired). Writes only in EXEC/MEM on ack.
//  rst_n asserted mid-request: mem_req drops immediately, no reg/pc update from that cycle.
//  Flags persist until the next CMP; not affected by other ops.
// TESTING
//  Reset, zero-wait mem with MOV r1,#5; ADD r2,r1,#3 -> r2=8 after 6 cycles, pc=2.
//  MOV r1,#7; CMP r1,#7; B eq,#0x10 -> flags=0001, pc=0x10; B gt path not taken -> pc+1.
//  STR r2,[#0x20] then LDR r3,[#0x20] with ack delayed 3 cycles -> req held, r3=8.
//  Opcode 7 fetched -> illegal=1, halted=1, mem_req stays 0, pc frozen.
//  pc=2^ADDR_W-1 fetch -> pc wraps to 0; rst_n low during wait-state -> state FETCH, pc=START_PC.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Bundles the memory req/ack port and the ALU operand/result port of the sequencer.
// The sequencer drives the bus as master; the memory and ALU sit on the slave side.
interface instr_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  logic [3:0]        alu_opcode;
  logic              alu_addressing_mode;
  logic [20:0]       alu_immediate;
  logic [31:0]       alu_reg_a_data;
  logic [31:0]       alu_reg_b_data;
  logic [31:0]       alu_result;
  logic [3:0]        alu_cmp_result;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output alu_opcode, alu_addressing_mode, alu_immediate, alu_reg_a_data, alu_reg_b_data,
    input  alu_result, alu_cmp_result
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  alu_opcode, alu_addressing_mode, alu_immediate, alu_reg_a_data, alu_reg_b_data,
    output alu_result, alu_cmp_result
  );
endinterface

// File: rtl/instr_sequencer.sv
// Non-pipelined fetch/decode/execute controller with an 8x32 register file.
// Instructions and LDR/STR data share one req/ack memory port; arithmetic is done by an external ALU.
module instr_sequencer #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] START_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_sequencer_if.master bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_e;

  localparam logic [3:0] OP_LDR = 4'h0, OP_STR = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                         OP_MOV = 4'h4, OP_CMP = 4'h5, OP_B   = 4'h6, OP_AND = 4'h8,
                         OP_ORR = 4'h9, OP_EOR = 4'hA, OP_MVN = 4'hB, OP_LSL = 4'hC,
                         OP_LSR = 4'hD, OP_HLT = 4'hF;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       ir_q, ir_d;
  logic [3:0]        flags_q, flags_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  logic [31:0]       regs_q [8];

  logic              rf_we;
  logic [31:0]       rf_wdata;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic              taken;

  logic [3:0] op;
  logic [2:0] rd, ra, rb;
  assign op = ir_q[31:28];
  assign rd = ir_q[26:24];
  assign ra = ir_q[23:21];
  assign rb = ir_q[2:0];

  assign bus.alu_opcode          = op;
  assign bus.alu_addressing_mode = ir_q[27];
  assign bus.alu_immediate       = ir_q[20:0];
  assign bus.alu_reg_a_data      = regs_q[ra];
  assign bus.alu_reg_b_data      = regs_q[rb];

  // Request strobes are qualified by rst_n so a reset mid-request withdraws them at once.
  assign bus.mem_req   = req & rst_n;
  assign bus.mem_we    = we & rst_n;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = regs_q[rd];

  assign pc      = pc_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

  always_comb begin
    case (rd)
      3'd0:    taken = 1'b1;
      3'd1:    taken = flags_q[0];
      3'd2:    taken = flags_q[1];
      3'd3:    taken = flags_q[2];
      3'd4:    taken = flags_q[3];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    flags_d   = flags_q;
    addr_d    = addr_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_wdata  = '0;
    req       = 1'b0;
    we        = 1'b0;
    addr      = pc_q;
    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (bus.mem_ack) begin
          ir_d    = bus.mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_MOV, OP_AND, OP_ORR, OP_EOR, OP_MVN, OP_LSL, OP_LSR: begin
            rf_we    = 1'b1;
            rf_wdata = bus.alu_result;
          end
          OP_CMP: flags_d = bus.alu_cmp_result;
          OP_B: if (taken) pc_d = ir_q[ADDR_W-1:0];
          OP_LDR, OP_STR: begin
            addr_d  = bus.alu_result[ADDR_W-1:0];
            state_d = S_MEM;
          end
          OP_HLT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: begin
            illegal_d = 1'b1;
            halted_d  = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        req  = 1'b1;
        we   = (op == OP_STR);
        addr = addr_q;
        if (bus.mem_ack) begin
          if (op == OP_LDR) begin
            rf_we    = 1'b1;
            rf_wdata = bus.mem_rdata;
          end
          state_d = S_FETCH;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= START_PC;
      ir_q      <= '0;
      flags_q   <= '0;
      addr_q    <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      flags_q   <= flags_d;
      addr_q    <= addr_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      if (rf_we) regs_q[rd] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench: a 256-word memory with programmable ack latency and a behavioural ALU
// surround the sequencer; register contents are observed through ALU operands and stores.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic        halted;
  logic        illegal;

  logic [31:0] mem [256];
  int          errors = 0;
  int          checks = 0;
  int          fetchDelay = 0;
  int          dataDelay = 0;
  int          waitCnt;
  int          curDelay;
  logic [31:0] op2;
  logic [31:0] opa;

  always #5 clk = ~clk;

  instr_sequencer_if #(.ADDR_W(16)) bus ();

  instr_sequencer #(.ADDR_W(16), .START_PC(16'h0000)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.master),
    .pc      (pc),
    .halted  (halted),
    .illegal (illegal)
  );

  // Addresses 0x20-0x3F form the slow data region; everything else uses the fetch latency.
  always_comb begin
    curDelay      = (bus.mem_addr[7:5] == 3'b001) ? dataDelay : fetchDelay;
    bus.mem_ack   = bus.mem_req && (waitCnt >= curDelay);
    bus.mem_rdata = mem[bus.mem_addr[7:0]];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) waitCnt <= 0;
    else if (bus.mem_req && !bus.mem_ack) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  always @(posedge clk) begin
    if (rst_n && bus.mem_req && bus.mem_we && bus.mem_ack)
      mem[bus.mem_addr[7:0]] = bus.mem_wdata;
  end

  always_comb begin
    opa = bus.alu_reg_a_data;
    op2 = bus.alu_addressing_mode ? bus.alu_reg_b_data : {11'b0, bus.alu_immediate};
    case (bus.alu_opcode)
      4'h0, 4'h1, 4'h2: bus.alu_result = opa + op2;
      4'h3:             bus.alu_result = opa - op2;
      4'h4:             bus.alu_result = op2;
      4'h8:             bus.alu_result = opa & op2;
      4'h9:             bus.alu_result = opa | op2;
      4'hA:             bus.alu_result = opa ^ op2;
      4'hB:             bus.alu_result = ~op2;
      4'hC:             bus.alu_result = opa << op2[4:0];
      4'hD:             bus.alu_result = opa >> op2[4:0];
      default:          bus.alu_result = 32'h0;
    endcase
    bus.alu_cmp_result = {opa > op2, opa < op2, opa != op2, opa == op2};
  end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic mode,
                                      input logic [2:0] rd, input logic [2:0] ra,
                                      input logic [20:0] imm);
    return {op, mode, rd, ra, imm};
  endfunction

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = enc(4'h4, 1'b0, 3'd1, 3'd0, 21'd5);
    mem[8'h01] = enc(4'h2, 1'b0, 3'd2, 3'd1, 21'd3);
    mem[8'h02] = enc(4'h4, 1'b0, 3'd1, 3'd0, 21'd7);
    mem[8'h03] = enc(4'h5, 1'b0, 3'd0, 3'd1, 21'd7);
    mem[8'h04] = enc(4'h6, 1'b0, 3'd1, 3'd0, 21'h10);
    mem[8'h10] = enc(4'h6, 1'b0, 3'd4, 3'd0, 21'h30);
    mem[8'h11] = enc(4'h1, 1'b0, 3'd2, 3'd0, 21'h20);
    mem[8'h12] = enc(4'h0, 1'b0, 3'd3, 3'd0, 21'h20);
    mem[8'h13] = enc(4'h1, 1'b0, 3'd3, 3'd0, 21'h21);
    mem[8'h14] = enc(4'h6, 1'b0, 3'd0, 3'd0, 21'h0FFFF);
    mem[8'hFF] = enc(4'h4, 1'b0, 3'd4, 3'd0, 21'd9);

    rst_n = 1'b0;
    applyStimulus(3);
    checkOutput("reset_mem_req", {31'b0, bus.mem_req}, 32'd0);
    checkOutput("reset_mem_we", {31'b0, bus.mem_we}, 32'd0);
    checkOutput("reset_pc", {16'b0, pc}, 32'h0);
    checkOutput("reset_halted", {31'b0, halted}, 32'd0);
    checkOutput("reset_illegal", {31'b0, illegal}, 32'd0);
    checkOutput("reset_opcode", {28'b0, bus.alu_opcode}, 32'd0);

    rst_n = 1'b1;
    applyStimulus(6);
    checkOutput("add_pc", {16'b0, pc}, 32'h2);
    checkOutput("add_opcode", {28'b0, bus.alu_opcode}, 32'h2);
    checkOutput("add_r1_operand", bus.alu_reg_a_data, 32'd5);
    checkOutput("add_imm", {11'b0, bus.alu_immediate}, 32'd3);

    applyStimulus(6);
    checkOutput("cmp_pc", {16'b0, pc}, 32'h4);
    checkOutput("cmp_opcode", {28'b0, bus.alu_opcode}, 32'h5);
    applyStimulus(3);
    checkOutput("beq_taken_pc", {16'b0, pc}, 32'h10);
    applyStimulus(3);
    checkOutput("bgt_not_taken_pc", {16'b0, pc}, 32'h11);

    dataDelay = 3;
    applyStimulus(3);
    checkOutput("str_req", {31'b0, bus.mem_req}, 32'd1);
    checkOutput("str_we", {31'b0, bus.mem_we}, 32'd1);
    checkOutput("str_addr", {16'b0, bus.mem_addr}, 32'h20);
    checkOutput("str_wdata_r2", bus.mem_wdata, 32'd8);
    applyStimulus(2);
    checkOutput("str_req_held", {31'b0, bus.mem_req}, 32'd1);
    checkOutput("str_addr_held", {16'b0, bus.mem_addr}, 32'h20);
    checkOutput("str_we_held", {31'b0, bus.mem_we}, 32'd1);
    applyStimulus(2);
    checkOutput("str_done_fetch_addr", {16'b0, bus.mem_addr}, 32'h12);
    checkOutput("str_done_we", {31'b0, bus.mem_we}, 32'd0);
    checkOutput("str_mem_0x20", mem[8'h20], 32'd8);

    applyStimulus(7);
    checkOutput("ldr_done_fetch_addr", {16'b0, bus.mem_addr}, 32'h13);
    applyStimulus(3);
    checkOutput("str2_addr", {16'b0, bus.mem_addr}, 32'h21);
    checkOutput("str2_wdata_r3", bus.mem_wdata, 32'd8);
    applyStimulus(4);
    checkOutput("str2_mem_0x21", mem[8'h21], 32'd8);
    checkOutput("str2_done_pc", {16'b0, pc}, 32'h14);

    applyStimulus(3);
    checkOutput("bal_pc_max", {16'b0, pc}, 32'hFFFF);
    applyStimulus(1);
    checkOutput("pc_wrap", {16'b0, pc}, 32'h0);
    checkOutput("wrap_fetched_opcode", {28'b0, bus.alu_opcode}, 32'h4);

    applyStimulus(3);
    fetchDelay = 3;
    applyStimulus(3);
    checkOutput("wait_req_held", {31'b0, bus.mem_req}, 32'd1);
    checkOutput("wait_pc", {16'b0, pc}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreq_reset_req", {31'b0, bus.mem_req}, 32'd0);
    checkOutput("midreq_reset_pc", {16'b0, pc}, 32'h0);
    checkOutput("midreq_reset_ir", {28'b0, bus.alu_opcode}, 32'h0);
    applyStimulus(2);
    checkOutput("reset_hold_pc", {16'b0, pc}, 32'h0);

    fetchDelay = 0;
    mem[8'h00] = enc(4'h7, 1'b0, 3'd0, 3'd0, 21'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("restart_req", {31'b0, bus.mem_req}, 32'd1);
    checkOutput("restart_addr", {16'b0, bus.mem_addr}, 32'h0);
    applyStimulus(3);
    checkOutput("illegal_flag", {31'b0, illegal}, 32'd1);
    checkOutput("illegal_halted", {31'b0, halted}, 32'd1);
    checkOutput("illegal_req", {31'b0, bus.mem_req}, 32'd0);
    checkOutput("illegal_pc", {16'b0, pc}, 32'h1);
    applyStimulus(4);
    checkOutput("halt_pc_frozen", {16'b0, pc}, 32'h1);
    checkOutput("halt_req_low", {31'b0, bus.mem_req}, 32'd0);
    checkOutput("halt_sticky", {31'b0, halted}, 32'd1);

    rst_n = 1'b0;
    #1;
    checkOutput("reset_clears_illegal", {31'b0, illegal}, 32'd0);
    mem[8'h00] = enc(4'hF, 1'b0, 3'd0, 3'd0, 21'd0);
    applyStimulus(1);
    rst_n = 1'b1;
    applyStimulus(3);
    checkOutput("halt_op_halted", {31'b0, halted}, 32'd1);
    checkOutput("halt_op_not_illegal", {31'b0, illegal}, 32'd0);
    checkOutput("halt_op_req", {31'b0, bus.mem_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
